// File: rtl/gpio_arb_pkg.sv
// Shared definitions for the GPIO interrupt arbiter.
// Contents: FSM state type, timeout counter width and a ceil(log2) helper
// that the top level uses to validate ID_WIDTH against PIN_COUNT.
package gpio_arb_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StPresent = 2'd1,
    StClear   = 2'd2,
    StSettle  = 2'd3
  } arb_state_e;

  localparam int unsigned TimeoutCntWidth = 16;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/gpio_int_arbiter_if.sv
// Interrupt request handshake between the arbiter and the CPU/interrupt controller.
// Signals: irq_valid (ID presented), irq_id (pin index), irq_ready (consumer accepts),
// irq_timeout (one-cycle pulse when a handshake is abandoned).
// Modports: master = arbiter side, slave = consumer side.
interface gpio_int_arbiter_if #(
  parameter int unsigned ID_WIDTH = 5
) ();

  logic                irq_valid;
  logic [ID_WIDTH-1:0] irq_id;
  logic                irq_ready;
  logic                irq_timeout;

  modport master (
    output irq_valid,
    output irq_id,
    output irq_timeout,
    input  irq_ready
  );

  modport slave (
    input  irq_valid,
    input  irq_id,
    input  irq_timeout,
    output irq_ready
  );

endinterface

// File: rtl/gpio_rr_picker.sv
// Round-robin picker: finds the first set bit of eligible at or above (rr_ptr+1) mod PIN_COUNT,
// wrapping around. Purely combinational.
// Ports: eligible (request vector), rr_ptr (last granted index), found (any request), idx (winner).
module gpio_rr_picker #(
  parameter int unsigned PIN_COUNT = 32,
  parameter int unsigned ID_WIDTH  = 5
) (
  input  logic [PIN_COUNT-1:0] eligible,
  input  logic [ID_WIDTH-1:0]  rr_ptr,
  output logic                 found,
  output logic [ID_WIDTH-1:0]  idx
);

  logic [ID_WIDTH-1:0]  start;
  logic [PIN_COUNT-1:0] rot;
  logic [ID_WIDTH-1:0]  pos;
  logic [ID_WIDTH:0]    sum;

  assign start = (rr_ptr == ID_WIDTH'(PIN_COUNT - 1)) ? '0 : rr_ptr + ID_WIDTH'(1);

  // Rotate so that bit 0 of rot corresponds to pin 'start'.
  assign rot = PIN_COUNT'({eligible, eligible} >> start);

  // Lowest set bit wins; the downward loop leaves the lowest index last.
  always_comb begin
    pos   = '0;
    found = 1'b0;
    for (int i = PIN_COUNT - 1; i >= 0; i--) begin
      if (rot[i]) begin
        pos   = ID_WIDTH'(i);
        found = 1'b1;
      end
    end
  end

  // Un-rotate: idx = (start + pos) mod PIN_COUNT.
  always_comb begin
    sum = {1'b0, start} + {1'b0, pos};
    if (sum >= (ID_WIDTH + 1)'(PIN_COUNT)) sum = sum - (ID_WIDTH + 1)'(PIN_COUNT);
    idx = sum[ID_WIDTH-1:0];
  end

endmodule

// File: rtl/gpio_int_arbiter.sv
// GPIO interrupt arbiter: picks one pending, unmasked pin round-robin, presents its ID
// on a valid/ready handshake, pulses int_clear for that pin once accepted, then waits one
// cycle for the GPIO status to settle before the next grant.
// Ports: clk, rst_n (async, active-low), arb_en (allow new grants), int_status, int_mask,
// int_clear (one-hot clear pulse), pending_cnt (popcount of eligible, combinational),
// irq (gpio_int_arbiter_if.master: irq_valid, irq_id, irq_ready, irq_timeout).
// Optional: define GPIO_INT_ARB_TIMEOUT_EN to abandon a handshake after TIMEOUT_CYCLES
// cycles in PRESENT without irq_ready.
module gpio_int_arbiter
  import gpio_arb_pkg::*;
#(
  parameter int unsigned PIN_COUNT      = 32,
  parameter int unsigned ID_WIDTH       = 5,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 arb_en,
  input  logic [PIN_COUNT-1:0] int_status,
  input  logic [PIN_COUNT-1:0] int_mask,
  output logic [PIN_COUNT-1:0] int_clear,
  output logic [ID_WIDTH:0]    pending_cnt,
  gpio_int_arbiter_if.master   irq
);

  if (ID_WIDTH != clog2(PIN_COUNT) || PIN_COUNT < 2 || PIN_COUNT > 64) begin : gen_cfg_chk
    $error("gpio_int_arbiter: illegal PIN_COUNT/ID_WIDTH");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= (1 << TimeoutCntWidth)) begin : gen_tmo_chk
    $error("gpio_int_arbiter: illegal TIMEOUT_CYCLES");
  end

  arb_state_e           state_q, state_d;
  logic [ID_WIDTH-1:0]  irq_id_q, irq_id_d;
  logic [ID_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
  logic                 irq_valid_q, irq_valid_d;
  logic [PIN_COUNT-1:0] int_clear_q, int_clear_d;
  logic [PIN_COUNT-1:0] eligible;
  logic                 pick_found;
  logic [ID_WIDTH-1:0]  pick_idx;

  assign eligible = int_status & ~int_mask;

  always_comb begin
    pending_cnt = '0;
    for (int i = 0; i < PIN_COUNT; i++) begin
      if (eligible[i]) pending_cnt = pending_cnt + (ID_WIDTH + 1)'(1);
    end
  end

  gpio_rr_picker #(
    .PIN_COUNT(PIN_COUNT),
    .ID_WIDTH (ID_WIDTH)
  ) u_picker (
    .eligible(eligible),
    .rr_ptr  (rr_ptr_q),
    .found   (pick_found),
    .idx     (pick_idx)
  );

`ifdef GPIO_INT_ARB_TIMEOUT_EN
  logic [TimeoutCntWidth-1:0] cnt_q, cnt_d;
  logic                       timeout_q, timeout_d;
`endif

  always_comb begin
    state_d     = state_q;
    irq_id_d    = irq_id_q;
    rr_ptr_d    = rr_ptr_q;
    irq_valid_d = 1'b0;
    int_clear_d = '0;
`ifdef GPIO_INT_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    timeout_d   = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        if (arb_en && pick_found) begin
          state_d     = StPresent;
          irq_id_d    = pick_idx;
          irq_valid_d = 1'b1;
`ifdef GPIO_INT_ARB_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end
      StPresent: begin
        // Request is held regardless of later mask/status changes or arb_en.
        if (irq.irq_ready) begin
          state_d     = StClear;
          rr_ptr_d    = irq_id_q;
          int_clear_d = PIN_COUNT'(1) << irq_id_q;
`ifdef GPIO_INT_ARB_TIMEOUT_EN
        end else if (cnt_q == TimeoutCntWidth'(TIMEOUT_CYCLES - 1)) begin
          state_d   = StIdle;
          rr_ptr_d  = irq_id_q;
          timeout_d = 1'b1;
        end else begin
          irq_valid_d = 1'b1;
          cnt_d       = cnt_q + TimeoutCntWidth'(1);
`else
        end else begin
          irq_valid_d = 1'b1;
`endif
        end
      end
      StClear:  state_d = StSettle;
      // GPIO status drops one edge after the clear; skip a cycle so it is not re-granted.
      StSettle: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      irq_id_q    <= '0;
      rr_ptr_q    <= ID_WIDTH'(PIN_COUNT - 1);
      irq_valid_q <= 1'b0;
      int_clear_q <= '0;
    end else begin
      state_q     <= state_d;
      irq_id_q    <= irq_id_d;
      rr_ptr_q    <= rr_ptr_d;
      irq_valid_q <= irq_valid_d;
      int_clear_q <= int_clear_d;
    end
  end

`ifdef GPIO_INT_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
  assign irq.irq_timeout = timeout_q;
`else
  assign irq.irq_timeout = 1'b0;
`endif

  assign irq.irq_valid = irq_valid_q;
  assign irq.irq_id    = irq_id_q;
  assign int_clear     = int_clear_q;

endmodule
